// File: rtl/depth_frag_scheduler_if.sv
// Fragment/frame-control bundle between the rasterizer front end, the scheduler and the depth write stage.
// Clock and reset stay outside the bundle.
interface depth_frag_scheduler_if #(
  parameter int FB_ADDR_WIDTH   = 17,
  parameter int FB_BIT_WIDTH    = 16,
  parameter int DEPTH_BIT_WIDTH = 16
);
  logic                       frame_start_in;
  logic                       target_front_in;
  logic                       frag_valid_in;
  logic                       frag_ready_out;
  logic [FB_ADDR_WIDTH-1:0]   frag_addr_in;
  logic [FB_BIT_WIDTH-1:0]    frag_color_in;
  logic [DEPTH_BIT_WIDTH-1:0] frag_depth_in;
  logic                       frag_last_in;
  logic                       drawing_out;
  logic                       fb_we_out;
  logic                       dp_we_out;
  logic                       dp_re_out;
  logic                       fb_front_out;
  logic [FB_ADDR_WIDTH-1:0]   fb_write_out;
  logic [FB_BIT_WIDTH-1:0]    fb_value_out;
  logic [FB_ADDR_WIDTH-1:0]   dp_write_out;
  logic [DEPTH_BIT_WIDTH-1:0] dp_value_out;
  logic                       busy_out;
  logic                       frame_done_out;

  modport master (
    output frame_start_in, target_front_in, frag_valid_in, frag_addr_in,
           frag_color_in, frag_depth_in, frag_last_in,
    input  frag_ready_out, drawing_out, fb_we_out, dp_we_out, dp_re_out,
           fb_front_out, fb_write_out, fb_value_out, dp_write_out, dp_value_out,
           busy_out, frame_done_out
  );

  modport slave (
    input  frame_start_in, target_front_in, frag_valid_in, frag_addr_in,
           frag_color_in, frag_depth_in, frag_last_in,
    output frag_ready_out, drawing_out, fb_we_out, dp_we_out, dp_re_out,
           fb_front_out, fb_write_out, fb_value_out, dp_write_out, dp_value_out,
           busy_out, frame_done_out
  );
endinterface

// File: rtl/depth_frag_scheduler.sv
// Per-frame clear sweep, then one-per-cycle fragment issue into the fixed-latency depth pipe, stalling same-address issues.
// Outputs registered (one cycle after accept); upstream sees frag_ready_out, downstream never back-pressures.
module depth_frag_scheduler #(
  parameter int                         FB_ADDR_WIDTH   = 17,
  parameter int                         FB_BIT_WIDTH    = 16,
  parameter int                         DEPTH_BIT_WIDTH = 16,
  parameter int                         FB_SIZE         = 76800,
  parameter int                         HAZARD_DEPTH    = 6,
  parameter logic [FB_BIT_WIDTH-1:0]    CLEAR_COLOR     = '0,
  parameter logic [DEPTH_BIT_WIDTH-1:0] CLEAR_DEPTH     = '1
) (
  input logic                   clk_in,
  input logic                   rst_in,
  depth_frag_scheduler_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DRAW, S_DRAIN} state_t;

  // The issue cycle itself is one of the blocking cycles, so only HAZARD_DEPTH-1 older entries are compared.
  localparam int HIST      = (HAZARD_DEPTH > 1) ? HAZARD_DEPTH - 1 : 1;
  localparam int DRAIN_CYC = HAZARD_DEPTH + 4;
  localparam int DCW       = $clog2(DRAIN_CYC);

  state_t                     state_q;
  logic [FB_ADDR_WIDTH-1:0]   clr_addr_q;
  logic [DCW-1:0]             drain_cnt_q;
  logic                       front_q;

  logic                       hold_vld_q;
  logic                       hold_last_q;
  logic [FB_ADDR_WIDTH-1:0]   hold_addr_q;
  logic [FB_BIT_WIDTH-1:0]    hold_color_q;
  logic [DEPTH_BIT_WIDTH-1:0] hold_depth_q;

  logic                       hist_vld_q  [HIST];
  logic [FB_ADDR_WIDTH-1:0]   hist_addr_q [HIST];

  logic                       drawing_q;
  logic                       fb_we_q;
  logic                       dp_we_q;
  logic                       dp_re_q;
  logic                       frame_done_q;
  logic [FB_ADDR_WIDTH-1:0]   wr_addr_q;
  logic [FB_BIT_WIDTH-1:0]    fb_value_q;
  logic [DEPTH_BIT_WIDTH-1:0] dp_value_q;

  logic hazard;
  logic hold_oob;
  logic hold_go;
  logic hold_issue;
  logic frag_ready;
  logic accept;
  logic clr_last;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HIST; i++) begin
      if (hist_vld_q[i] && (hist_addr_q[i] == hold_addr_q)) hazard = 1'b1;
    end
    if (HAZARD_DEPTH <= 1) hazard = 1'b0;
  end

  // Out-of-range fragments leave the hold without a write and without touching the hazard history.
  assign hold_oob   = {1'b0, hold_addr_q} >= (FB_ADDR_WIDTH + 1)'(FB_SIZE);
  assign hold_go    = ((state_q == S_DRAW) || (state_q == S_DRAIN)) && hold_vld_q && (hold_oob || !hazard);
  assign hold_issue = hold_go && !hold_oob;
  assign frag_ready = (state_q == S_DRAW) && (!hold_vld_q || hold_go);
  assign accept     = bus.frag_valid_in && frag_ready;
  assign clr_last   = clr_addr_q == FB_ADDR_WIDTH'(FB_SIZE - 1);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      clr_addr_q   <= '0;
      drain_cnt_q  <= '0;
      front_q      <= 1'b0;
      hold_vld_q   <= 1'b0;
      hold_last_q  <= 1'b0;
      hold_addr_q  <= '0;
      hold_color_q <= '0;
      hold_depth_q <= '0;
      for (int i = 0; i < HIST; i++) begin
        hist_vld_q[i]  <= 1'b0;
        hist_addr_q[i] <= '0;
      end
      drawing_q    <= 1'b0;
      fb_we_q      <= 1'b0;
      dp_we_q      <= 1'b0;
      dp_re_q      <= 1'b0;
      frame_done_q <= 1'b0;
      wr_addr_q    <= '0;
      fb_value_q   <= '0;
      dp_value_q   <= '0;
    end else begin
      hist_vld_q[0]  <= hold_issue;
      hist_addr_q[0] <= hold_addr_q;
      for (int i = 1; i < HIST; i++) begin
        hist_vld_q[i]  <= hist_vld_q[i-1];
        hist_addr_q[i] <= hist_addr_q[i-1];
      end

      drawing_q    <= 1'b0;
      fb_we_q      <= 1'b0;
      dp_we_q      <= 1'b0;
      dp_re_q      <= 1'b0;
      frame_done_q <= 1'b0;

      // Held entry leaves first; a new fragment may refill the hold on the same edge.
      if (hold_go) hold_vld_q <= 1'b0;
      if (accept) begin
        hold_vld_q   <= 1'b1;
        hold_last_q  <= bus.frag_last_in;
        hold_addr_q  <= bus.frag_addr_in;
        hold_color_q <= bus.frag_color_in;
        hold_depth_q <= bus.frag_depth_in;
      end

      if (hold_issue) begin
        drawing_q  <= 1'b1;
        fb_we_q    <= 1'b1;
        dp_we_q    <= 1'b1;
        dp_re_q    <= 1'b1;
        wr_addr_q  <= hold_addr_q;
        fb_value_q <= hold_color_q;
        dp_value_q <= hold_depth_q;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.frame_start_in) begin
            front_q    <= bus.target_front_in;
            clr_addr_q <= '0;
            state_q    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          fb_we_q    <= 1'b1;
          dp_we_q    <= 1'b1;
          wr_addr_q  <= clr_addr_q;
          fb_value_q <= CLEAR_COLOR;
          dp_value_q <= CLEAR_DEPTH;
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_last) state_q <= S_DRAW;
        end
        S_DRAW: begin
          if (hold_go && hold_last_q) begin
            drain_cnt_q <= '0;
            state_q     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          frame_done_q <= drain_cnt_q == DCW'(DRAIN_CYC - 2);
          if (drain_cnt_q == DCW'(DRAIN_CYC - 1)) state_q <= S_IDLE;
          else drain_cnt_q <= drain_cnt_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.frag_ready_out = frag_ready;
  assign bus.drawing_out    = drawing_q;
  assign bus.fb_we_out      = fb_we_q;
  assign bus.dp_we_out      = dp_we_q;
  assign bus.dp_re_out      = dp_re_q;
  assign bus.fb_front_out   = front_q;
  assign bus.fb_write_out   = wr_addr_q;
  assign bus.dp_write_out   = wr_addr_q;
  assign bus.fb_value_out   = fb_value_q;
  assign bus.dp_value_out   = dp_value_q;
  assign bus.busy_out       = state_q != S_IDLE;
  assign bus.frame_done_out = frame_done_q;

endmodule

// File: tb/tb_depth_frag_scheduler.sv
// Bench for depth_frag_scheduler: vector table for issue/hazard timing, hand sequences for clear/drain/reset,
// and a randomized fragment stream checked against a timestamp-based issue model.
module tb_depth_frag_scheduler;
  localparam int AW  = 17;
  localparam int CW  = 16;
  localparam int DW  = 16;
  localparam int FBS = 16;
  localparam int HD  = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  depth_frag_scheduler_if #(.FB_ADDR_WIDTH(AW), .FB_BIT_WIDTH(CW), .DEPTH_BIT_WIDTH(DW)) bus ();

  depth_frag_scheduler #(
    .FB_ADDR_WIDTH(AW), .FB_BIT_WIDTH(CW), .DEPTH_BIT_WIDTH(DW),
    .FB_SIZE(FBS), .HAZARD_DEPTH(HD)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic vld;
    int   addr;
    int   depth;
    logic exp_rdy;
    logic exp_draw;
    int   exp_addr;
    int   exp_depth;
  } vec_t;

  function automatic vec_t mk(logic v, int a, int d, logic r, logic dr, int ea, int ed);
    vec_t t;
    t.vld = v; t.addr = a; t.depth = d; t.exp_rdy = r; t.exp_draw = dr; t.exp_addr = ea; t.exp_depth = ed;
    return t;
  endfunction

  // Reference model: hold slot plus last-issue edge per address.
  int   last_iss [0:31];
  logic m_hv, m_hl, m_draw;
  int   m_ha, m_hc, m_hd;
  int   cyc;

  task automatic step(input logic v, input int a, input int c, input int d, input logic l, output logic acc);
    logic oob, go, rdy;
    oob = (m_ha >= FBS);
    go  = m_hv && (oob || (cyc - last_iss[m_ha] >= HD));
    rdy = m_draw && (!m_hv || go);
    bus.frag_valid_in = v;
    bus.frag_addr_in  = AW'(a);
    bus.frag_color_in = CW'(c);
    bus.frag_depth_in = DW'(d);
    bus.frag_last_in  = l;
    #1;
    chk("rand_ready", 32'(bus.frag_ready_out), 32'(rdy));
    acc = v && rdy;
    tick();
    if (go && !oob) begin
      last_iss[m_ha] = cyc;
      chk("rand_drawing", 32'(bus.drawing_out), 32'd1);
      chk("rand_addr", 32'(bus.fb_write_out), 32'(m_ha));
      chk("rand_color", 32'(bus.fb_value_out), 32'(m_hc));
      chk("rand_depth", 32'(bus.dp_value_out), 32'(m_hd));
    end else begin
      chk("rand_bubble", 32'(bus.drawing_out), 32'd0);
    end
    cyc++;
    if (go) begin
      m_hv = 1'b0;
      if (m_hl) m_draw = 1'b0;
    end
    if (acc) begin
      m_hv = 1'b1; m_ha = a; m_hc = c; m_hd = d; m_hl = l;
    end
  endtask

  vec_t tbl [13];

  initial begin
    logic acc;
    int   done_k, pulses;

    tbl[0]  = mk(1, 3, 10, 1, 0, 0, 0);
    tbl[1]  = mk(1, 4, 10, 1, 1, 3, 10);
    tbl[2]  = mk(1, 5, 10, 1, 1, 4, 10);
    tbl[3]  = mk(1, 7, 20, 1, 1, 5, 10);
    tbl[4]  = mk(1, 7, 21, 1, 1, 7, 20);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 1, 1, 7, 21);
    tbl[11] = mk(1, 8, 5, 1, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 1, 1, 8, 5);

    rst = 1'b1;
    bus.frame_start_in  = 1'b0;
    bus.target_front_in = 1'b0;
    bus.frag_valid_in   = 1'b0;
    bus.frag_addr_in    = '0;
    bus.frag_color_in   = '0;
    bus.frag_depth_in   = '0;
    bus.frag_last_in    = 1'b0;
    #12;
    chk("rst_busy", 32'(bus.busy_out), 32'd0);
    chk("rst_ready", 32'(bus.frag_ready_out), 32'd0);
    chk("rst_fb_we", 32'(bus.fb_we_out), 32'd0);
    chk("rst_done", 32'(bus.frame_done_out), 32'd0);
    rst = 1'b0;
    tick();

    // Clear sweep into the front buffer.
    bus.frame_start_in = 1'b1; bus.target_front_in = 1'b1;
    tick();
    bus.frame_start_in = 1'b0; bus.target_front_in = 1'b0;
    chk("clr_busy", 32'(bus.busy_out), 32'd1);
    for (int i = 0; i < FBS; i++) begin
      chk("clr_ready", 32'(bus.frag_ready_out), 32'd0);
      tick();
      chk("clr_we", 32'({bus.fb_we_out, bus.dp_we_out, bus.dp_re_out, bus.drawing_out}), 32'b1100);
      chk("clr_addr", 32'(bus.fb_write_out), 32'(i));
      chk("clr_dp_addr", 32'(bus.dp_write_out), 32'(i));
      chk("clr_vals", {bus.fb_value_out, bus.dp_value_out}, 32'h0000ffff);
      chk("clr_front", 32'(bus.fb_front_out), 32'd1);
    end
    chk("draw_ready", 32'(bus.frag_ready_out), 32'd1);

    // Back-to-back issue and same-address hazard.
    for (int i = 0; i < 13; i++) begin
      bus.frag_valid_in = tbl[i].vld;
      bus.frag_addr_in  = AW'(tbl[i].addr);
      bus.frag_depth_in = DW'(tbl[i].depth);
      bus.frag_color_in = CW'(tbl[i].depth + 1000);
      bus.frag_last_in  = 1'b0;
      #1;
      chk("tbl_ready", 32'(bus.frag_ready_out), 32'(tbl[i].exp_rdy));
      tick();
      chk("tbl_drawing", 32'(bus.drawing_out), 32'(tbl[i].exp_draw));
      chk("tbl_dp_re", 32'(bus.dp_re_out), 32'(tbl[i].exp_draw));
      if (tbl[i].exp_draw) begin
        chk("tbl_addr", 32'(bus.fb_write_out), 32'(tbl[i].exp_addr));
        chk("tbl_depth", 32'(bus.dp_value_out), 32'(tbl[i].exp_depth));
        chk("tbl_color", 32'(bus.fb_value_out), 32'(tbl[i].exp_depth + 1000));
      end
    end
    bus.frag_valid_in = 1'b0;

    // frame_start while drawing must not restart the clear.
    bus.frame_start_in = 1'b1;
    tick();
    bus.frame_start_in = 1'b0;
    tick();
    chk("ign_busy", 32'(bus.busy_out), 32'd1);
    chk("ign_fb_we", 32'(bus.fb_we_out), 32'd0);
    chk("ign_ready", 32'(bus.frag_ready_out), 32'd1);

    // Out-of-range last fragment: dropped, then drain and a single done pulse.
    bus.frag_valid_in = 1'b1; bus.frag_addr_in = AW'(20); bus.frag_last_in = 1'b1;
    #1;
    chk("oob_ready", 32'(bus.frag_ready_out), 32'd1);
    tick();
    bus.frag_valid_in = 1'b0; bus.frag_last_in = 1'b0;
    tick();
    chk("oob_no_write", 32'({bus.drawing_out, bus.fb_we_out}), 32'd0);
    chk("drain_busy", 32'(bus.busy_out), 32'd1);
    chk("drain_ready", 32'(bus.frag_ready_out), 32'd0);
    done_k = -1; pulses = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (bus.frame_done_out) begin
        pulses++;
        if (done_k < 0) done_k = k;
      end
    end
    chk("done_pulses", 32'(pulses), 32'd1);
    chk("done_cycle", 32'(done_k), 32'd9);
    chk("idle_busy", 32'(bus.busy_out), 32'd0);

    // Reset between edges in the middle of a clear.
    bus.frame_start_in = 1'b1; bus.target_front_in = 1'b1;
    tick();
    bus.frame_start_in = 1'b0;
    repeat (10) tick();
    chk("mid_clr_addr", 32'(bus.fb_write_out), 32'd9);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_we", 32'({bus.fb_we_out, bus.dp_we_out}), 32'd0);
    chk("arst_addr", 32'(bus.fb_write_out), 32'd0);
    chk("arst_busy", 32'(bus.busy_out), 32'd0);
    chk("arst_front", 32'(bus.fb_front_out), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 32'(bus.busy_out), 32'd0);
    bus.frame_start_in = 1'b1; bus.target_front_in = 1'b0;
    tick();
    bus.frame_start_in = 1'b0;
    tick();
    chk("restart_addr", 32'(bus.fb_write_out), 32'd0);
    chk("restart_we", 32'(bus.fb_we_out), 32'd1);
    repeat (15) tick();
    chk("restart_end", 32'(bus.fb_write_out), 32'(FBS - 1));

    // Randomized stream against the model.
    for (int i = 0; i < 32; i++) last_iss[i] = -100;
    m_hv = 1'b0; m_hl = 1'b0; m_draw = 1'b1; m_ha = 0; m_hc = 0; m_hd = 0; cyc = 0;
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) < 7), int'($urandom_range(0, 19)), int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 65535)), 1'b0, acc);
    end
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      step(1'b1, int'($urandom_range(0, FBS - 1)), 16'h1234, 16'h0042, 1'b1, acc);
    end
    chk("rand_last_acc", 32'(acc), 32'd1);
    for (int i = 0; i < 20 && m_hv; i++) step(1'b0, 0, 0, 0, 1'b0, acc);
    chk("rand_hold_empty", 32'(m_hv), 32'd0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.frame_done_out) pulses++;
    end
    chk("rand_done", 32'(pulses), 32'd1);
    chk("rand_idle", 32'(bus.busy_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
